cart_bus_responder: RTL and testbench

Board/testbench-side responder for the VerilogBoy chip's multiplexed external bus. Tracks the 4-phase bus cycle from `cale`, latches the address, and serves reads/writes to three asynchronous-read memories:
- 16 KB video/work SRAM
- cartridge ROM
- cartridge RAM

It contains an MBC1-style bank controller and a phase-lock monitor. It sits between the chip's pads and the memory models/FPGA memories.

---
 rtl/cart_bus_pkg.sv | 31 +++
 rtl/mbc1_regs.sv | 60 ++++++
 rtl/cart_bus_responder.sv | 149 ++++++++++++++
 tb/tb_cart_bus_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// Shared constants for the cartridge bus responder: address ranges, MBC1
// register regions (selected by a[14:13]) and the 4-phase bus encoding.
package cart_bus_pkg;

  localparam logic [15:0] CROM_BASE  = 16'h0000;
  localparam logic [15:0] CROM_LIMIT = 16'h7FFF;
  localparam logic [15:0] VRAM_BASE  = 16'h8000;
  localparam logic [15:0] VRAM_LIMIT = 16'h9FFF;
  localparam logic [15:0] CRAM_BASE  = 16'hA000;
  localparam logic [15:0] CRAM_LIMIT = 16'hBFFF;
  localparam logic [15:0] WRAM_BASE  = 16'hC000;
  localparam logic [15:0] WRAM_LIMIT = 16'hDFFF;

  localparam logic [1:0] MBC_RAM_EN  = 2'd0;
  localparam logic [1:0] MBC_BANK_LO = 2'd1;
  localparam logic [1:0] MBC_BANK_HI = 2'd2;
  localparam logic [1:0] MBC_MODE    = 2'd3;

  typedef enum logic [1:0] {
    PH_ADDR = 2'd0,
    PH_PPU0 = 2'd1,
    PH_CPU  = 2'd2,
    PH_PPU1 = 2'd3
  } phase_t;

  function automatic logic in_range(input logic [15:0] x, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 bank registers and the ROM / cartridge-RAM address mapping.
// Only instantiated when CART_MBC1_EN is defined.
module mbc1_regs
  import cart_bus_pkg::*;
#(
  parameter int ROM_AW  = 21,
  parameter int CRAM_AW = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [14:0]        a,
  input  logic [4:0]         d,
  output logic               ram_en,
  output logic [ROM_AW-1:0]  rom_a,
  output logic [CRAM_AW-1:0] cram_a
);

  logic [4:0]  bank_lo;
  logic [1:0]  bank_hi;
  logic        mode;
  logic [1:0]  hi_sel;
  logic [20:0] rom_full;
  logic [14:0] cram_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en  <= 1'b0;
      bank_lo <= 5'd1;
      bank_hi <= 2'd0;
      mode    <= 1'b0;
    end else if (we) begin
      case (a[14:13])
        MBC_RAM_EN:  ram_en  <= (d[3:0] == 4'hA);
        MBC_BANK_LO: bank_lo <= (d == 5'd0) ? 5'd1 : d;
        MBC_BANK_HI: bank_hi <= d[1:0];
        MBC_MODE:    mode    <= d[0];
        default: ;
      endcase
    end
  end

  // bank_hi only reaches the fixed 0000-3FFF window and cart RAM in mode 1
  assign hi_sel    = mode ? bank_hi : 2'b00;
  assign rom_full  = a[14] ? {bank_hi, bank_lo, a[13:0]} : {hi_sel, 5'b0, a[13:0]};
  assign cram_full = {hi_sel, a[12:0]};

  if (ROM_AW > 21) begin : g_rom_pad
    assign rom_a = {{(ROM_AW-21){1'b0}}, rom_full};
  end else begin : g_rom_trunc
    assign rom_a = rom_full[ROM_AW-1:0];
  end

  if (CRAM_AW > 15) begin : g_cram_pad
    assign cram_a = {{(CRAM_AW-15){1'b0}}, cram_full};
  end else begin : g_cram_trunc
    assign cram_a = cram_full[CRAM_AW-1:0];
  end

endmodule

// File: rtl/cart_bus_responder.sv
// Board-side responder for the multiplexed chip bus: phase tracking, address
// decode and memory strobes. Define CART_MBC1_EN for MBC1 banking.
//
// phase   | meaning
// PH_ADDR | cale high, address latched, bus idle
// PH_PPU0 | PPU read from live address
// PH_CPU  | CPU read/write decoded from latched address
// PH_PPU1 | PPU read from live address
module cart_bus_responder
  import cart_bus_pkg::*;
#(
  parameter int ROM_AW  = 21,
  parameter int CRAM_AW = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic [7:0]         dout,
  input  logic               doe,
  input  logic               wr,
  input  logic               cale,
  input  logic               cs,
  output logic [7:0]         din,
  output logic [13:0]        vram_a,
  input  logic [7:0]         vram_q,
  output logic [7:0]         vram_wd,
  output logic               vram_we,
  output logic [ROM_AW-1:0]  rom_a,
  input  logic [7:0]         rom_q,
  output logic [CRAM_AW-1:0] cram_a,
  input  logic [7:0]         cram_q,
  output logic [7:0]         cram_wd,
  output logic               cram_we,
  output logic               locked,
  output logic               sync_err
);

  phase_t      phase, phase_nxt;
  logic        locked_nxt;
  logic [15:0] addr_lat, addr_lat_nxt;
  logic [1:0]  phase_inc;
  logic        viol;
  logic        wr_ok, ram_en, mbc_we;
  logic        lat_crom, lat_cram, lat_vram, lat_wram, live_vram;
  logic        unused_doe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_ADDR;
      locked   <= 1'b0;
      addr_lat <= 16'h0000;
    end else begin
      phase    <= phase_nxt;
      locked   <= locked_nxt;
      addr_lat <= addr_lat_nxt;
    end
  end

  // Any cale while unlocked acquires lock; a violation while locked drops it
  always_comb begin
    phase_inc    = phase + 2'd1;
    phase_nxt    = phase_t'(phase_inc);
    locked_nxt   = locked;
    addr_lat_nxt = addr_lat;
    viol         = locked && (cale ? (phase != PH_ADDR) : (phase == PH_ADDR));
    if (cale) begin
      addr_lat_nxt = a;
      phase_nxt    = PH_PPU0;
      locked_nxt   = 1'b1;
    end
    if (viol) locked_nxt = 1'b0;
  end

  assign sync_err  = viol;
  assign wr_ok     = locked && (phase == PH_CPU) && wr && !viol;
  assign lat_crom  = (addr_lat <= CROM_LIMIT);
  assign lat_cram  = in_range(addr_lat, CRAM_BASE, CRAM_LIMIT);
  assign lat_vram  = in_range(addr_lat, VRAM_BASE, VRAM_LIMIT);
  assign lat_wram  = in_range(addr_lat, WRAM_BASE, WRAM_LIMIT);
  assign live_vram = in_range(a, VRAM_BASE, VRAM_LIMIT);

  always_comb begin
    din     = 8'hFF;
    vram_a  = {addr_lat[14], addr_lat[12:0]};
    vram_we = 1'b0;
    cram_we = 1'b0;
    mbc_we  = 1'b0;
    if (locked) begin
      case (phase)
        PH_PPU0, PH_PPU1: begin
          vram_a = {a[14], a[12:0]};
          if (live_vram) din = vram_q;
        end
        PH_CPU: begin
          if (cs) begin
            if (lat_crom) begin
              din    = rom_q;
              mbc_we = wr_ok;
            end else if (lat_cram && ram_en) begin
              din     = cram_q;
              cram_we = wr_ok;
            end
          end else if (lat_vram || lat_wram) begin
            din     = vram_q;
            vram_we = wr_ok;
          end
        end
        default: ;
      endcase
    end
  end

  assign vram_wd    = dout;
  assign cram_wd    = dout;
  assign unused_doe = doe;

`ifdef CART_MBC1_EN
  mbc1_regs #(
    .ROM_AW (ROM_AW),
    .CRAM_AW(CRAM_AW)
  ) u_mbc1_regs (
    .clk   (clk),
    .rst   (rst),
    .we    (mbc_we),
    .a     (addr_lat[14:0]),
    .d     (dout[4:0]),
    .ram_en(ram_en),
    .rom_a (rom_a),
    .cram_a(cram_a)
  );
`else
  logic unused_mbc_we;
  assign unused_mbc_we = mbc_we;
  assign ram_en        = 1'b1;

  if (ROM_AW > 15) begin : g_rom_pad
    assign rom_a = {{(ROM_AW-15){1'b0}}, addr_lat[14:0]};
  end else begin : g_rom_trunc
    assign rom_a = addr_lat[ROM_AW-1:0];
  end

  if (CRAM_AW > 13) begin : g_cram_pad
    assign cram_a = {{(CRAM_AW-13){1'b0}}, addr_lat[12:0]};
  end else begin : g_cram_trunc
    assign cram_a = addr_lat[CRAM_AW-1:0];
  end
`endif

endmodule

// File: tb/tb_cart_bus_responder.sv
// Scoreboard bench for cart_bus_responder: the driver pushes one expectation per
// clock from a behavioural bus model, a negedge monitor pops and compares.
module tb_cart_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  dout;
  logic        doe, wr, cale, cs;
  logic [7:0]  din;
  logic [13:0] vram_a;
  logic [7:0]  vram_q, vram_wd;
  logic        vram_we;
  logic [20:0] rom_a;
  logic [7:0]  rom_q;
  logic [14:0] cram_a;
  logic [7:0]  cram_q, cram_wd;
  logic        cram_we, locked, sync_err;

  always #5 clk = ~clk;

  cart_bus_responder #(.ROM_AW(21), .CRAM_AW(15)) dut (
    .clk(clk), .rst(rst), .a(a), .dout(dout), .doe(doe), .wr(wr), .cale(cale), .cs(cs),
    .din(din), .vram_a(vram_a), .vram_q(vram_q), .vram_wd(vram_wd), .vram_we(vram_we),
    .rom_a(rom_a), .rom_q(rom_q), .cram_a(cram_a), .cram_q(cram_q), .cram_wd(cram_wd),
    .cram_we(cram_we), .locked(locked), .sync_err(sync_err)
  );

  function automatic logic [7:0] rom_byte(input logic [20:0] x);
    logic [31:0] h;
    h = {11'b0, x} * 32'h9E3779B1;
    return h[31:24] ^ h[15:8];
  endfunction

  logic [7:0] vram_mem [16384];
  logic [7:0] cram_mem [32768];
  logic [7:0] vram_mdl [16384];
  logic [7:0] cram_mdl [32768];
  logic       init_mem;

  assign vram_q = vram_mem[vram_a];
  assign cram_q = cram_mem[cram_a];
  assign rom_q  = rom_byte(rom_a);

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16384; i++) vram_mem[i] <= vram_mdl[i];
      for (int i = 0; i < 32768; i++) cram_mem[i] <= cram_mdl[i];
    end else begin
      if (vram_we) vram_mem[vram_a] <= vram_wd;
      if (cram_we) cram_mem[cram_a] <= cram_wd;
    end
  end

  typedef struct {
    string       name;
    bit          chk_din;
    logic [7:0]  din;
    bit          vwe, cwe, serr, lock;
    bit          chk_va;
    logic [13:0] va;
    bit          chk_ra;
    logic [20:0] ra;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input string field, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", tag, field, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk_din) chk(mon_e.name, "din", din, mon_e.din);
      chk(mon_e.name, "vram_we", vram_we, mon_e.vwe);
      chk(mon_e.name, "cram_we", cram_we, mon_e.cwe);
      chk(mon_e.name, "sync_err", sync_err, mon_e.serr);
      chk(mon_e.name, "locked", locked, mon_e.lock);
      if (mon_e.chk_va) chk(mon_e.name, "vram_a", vram_a, mon_e.va);
      if (mon_e.chk_ra) chk(mon_e.name, "rom_a", rom_a, mon_e.ra);
    end
  end

  // Behavioural model state
  bit m_locked, m_ram_en;
  int m_lo, m_hi, m_mode;

  task automatic model_reset();
    m_locked = 0;
`ifdef CART_MBC1_EN
    m_ram_en = 0;
`else
    m_ram_en = 1;
`endif
    m_lo = 1; m_hi = 0; m_mode = 0;
  endtask

  function automatic int vidx(input logic [15:0] x);
    if (x >= 16'h8000 && x <= 16'h9FFF) return int'(x) - 'h8000;
    if (x >= 16'hC000 && x <= 16'hDFFF) return 'h2000 + int'(x) - 'hC000;
    return -1;
  endfunction

  function automatic int rom_idx(input logic [15:0] x);
`ifdef CART_MBC1_EN
    int bank;
    if (x < 16'h4000) bank = m_mode ? m_hi * 32 : 0;
    else              bank = m_hi * 32 + m_lo;
    return (bank * 16384 + int'(x) % 16384) % (1 << 21);
`else
    return int'(x);
`endif
  endfunction

  function automatic int cram_idx(input logic [15:0] x);
`ifdef CART_MBC1_EN
    return ((m_mode ? m_hi * 8192 : 0) + int'(x) - 'hA000) % 32768;
`else
    return int'(x) - 'hA000;
`endif
  endfunction

  task automatic mbc_write(input logic [15:0] x, input logic [7:0] d);
`ifdef CART_MBC1_EN
    case (int'(x) / 8192)
      0: m_ram_en = (d % 16 == 10);
      1: begin m_lo = d % 32; if (m_lo == 0) m_lo = 1; end
      2: m_hi = d % 4;
      default: m_mode = d % 2;
    endcase
`endif
  endtask

  function automatic exp_t blank(input string nm, input bit lk);
    exp_t e;
    e.name = nm; e.chk_din = 1; e.din = 8'hFF;
    e.vwe = 0; e.cwe = 0; e.serr = 0; e.lock = lk;
    e.chk_va = 0; e.va = '0; e.chk_ra = 0; e.ra = '0;
    return e;
  endfunction

  function automatic exp_t ppu_exp(input string nm, input logic [15:0] p);
    exp_t e;
    int   vi;
    e  = blank(nm, 1);
    vi = vidx(p);
    if (vi >= 0) begin
      e.chk_va = 1; e.va = 14'(vi);
      if (p <= 16'h9FFF) e.din = vram_mdl[vi];
    end
    return e;
  endfunction

  task automatic step(input bit c, input logic [15:0] ad, input bit cs_i, input bit wr_i,
                      input logic [7:0] d, input exp_t e);
    @(posedge clk); #1;
    cale = c; a = ad; cs = cs_i; wr = wr_i; doe = ~wr_i; dout = d;
    exp_q.push_back(e);
  endtask

  task automatic bus_cycle(input string nm, input logic [15:0] ad, input bit cs_i,
                           input bit wr_i, input logic [7:0] d, input logic [15:0] p);
    exp_t e;
    int   vi, ri, ci;
    step(1, ad, cs_i, wr_i, d, blank(nm, m_locked));
    m_locked = 1;
    step(0, p, cs_i, wr_i, d, ppu_exp(nm, p));
    e  = blank(nm, 1);
    vi = vidx(ad);
    ci = -1;
    if (wr_i) e.chk_din = 0;
    if (cs_i) begin
      if (ad < 16'h8000) begin
        if (!wr_i) begin
          ri = rom_idx(ad);
          e.din = rom_byte(21'(ri)); e.chk_ra = 1; e.ra = 21'(ri);
        end
      end else if (ad >= 16'hA000 && ad <= 16'hBFFF && m_ram_en) begin
        ci = cram_idx(ad);
        if (wr_i) e.cwe = 1; else e.din = cram_mdl[ci];
      end
    end else if (vi >= 0) begin
      e.chk_va = 1; e.va = 14'(vi);
      if (wr_i) e.vwe = 1; else e.din = vram_mdl[vi];
    end
    step(0, ad, cs_i, wr_i, d, e);
    if (wr_i) begin
      if (cs_i && ad < 16'h8000) mbc_write(ad, d);
      else if (cs_i && ci >= 0)  cram_mdl[ci] = d;
      else if (!cs_i && vi >= 0) vram_mdl[vi] = d;
    end
    step(0, p, cs_i, wr_i, d, ppu_exp(nm, p));
  endtask

  initial begin
    exp_t e;
    rst = 1; cale = 0; a = 0; cs = 0; wr = 0; doe = 1; dout = 0;
    for (int i = 0; i < 16384; i++) vram_mdl[i] = 8'($urandom);
    for (int i = 0; i < 32768; i++) cram_mdl[i] = 8'($urandom);
    vram_mdl['h1800] = 8'h3C;
    vram_mdl['h2123] = 8'h00;
    init_mem = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst = 0; init_mem = 0;

    step(0, 16'hFF40, 0, 0, 0, blank("reset", 0));
    step(0, 16'hFF40, 0, 0, 0, blank("reset", 0));
    repeat (3) bus_cycle("idle", 16'hFF40, 0, 0, 0, 16'hFF40);
    bus_cycle("wram_wr",  16'hC123, 0, 1, 8'h5A, 16'hFF40);
    bus_cycle("wram_rd",  16'hC123, 0, 0, 0,     16'h9800);
    bus_cycle("ppu_io",   16'hFF40, 0, 0, 0,     16'hFF40);
    bus_cycle("bank_lo0", 16'h2100, 1, 1, 8'h00, 16'hFF40);
    bus_cycle("bank_hi2", 16'h4000, 1, 1, 8'h02, 16'hFF40);
    bus_cycle("rom_4000", 16'h4000, 1, 0, 0,     16'h8010);
    bus_cycle("rom_0000", 16'h0000, 1, 0, 0,     16'hFF40);
    bus_cycle("cram_off", 16'hA000, 1, 0, 0,     16'hFF40);
    bus_cycle("ram_en",   16'h0000, 1, 1, 8'h0A, 16'hFF40);
    bus_cycle("cram_wr",  16'hA000, 1, 1, 8'h77, 16'hFF40);
    bus_cycle("cram_rd",  16'hA000, 1, 0, 0,     16'hA000);

    // cale arriving in the CPU phase
    step(1, 16'hC200, 0, 0, 0, blank("viol_p0", m_locked));
    m_locked = 1;
    step(0, 16'hFF40, 0, 0, 0, ppu_exp("viol_p1", 16'hFF40));
    e = blank("viol_cale", 1); e.serr = 1; e.chk_din = 0;
    step(1, 16'hC200, 0, 1, 8'hEE, e);
    m_locked = 0;
    repeat (3) step(0, 16'hC200, 0, 1, 8'hEE, blank("unlocked", 0));
    bus_cycle("relock",   16'hC200, 0, 0, 0, 16'hFF40);
    bus_cycle("viol_nowr", 16'hC200, 0, 0, 0, 16'hFF40);

    // missing cale in phase 0
    e = blank("viol_nocale", 1); e.serr = 1;
    step(0, 16'hFF40, 0, 0, 0, e);
    m_locked = 0;
    step(0, 16'hFF40, 0, 0, 0, blank("unlocked2", 0));
    bus_cycle("relock2", 16'h8005, 0, 0, 0, 16'h8005);

    for (int k = 0; k < 200; k++) begin
      int          sel;
      logic [15:0] ad, pp;
      bit          c_i, w_i;
      logic [7:0]  d;
      sel = $urandom_range(0, 5);
      c_i = ($urandom_range(0, 1) == 1);
      w_i = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      case (sel)
        0: begin ad = 16'h8000 + 16'($urandom_range(0, 15)); c_i = ($urandom_range(0, 4) == 0); end
        1: begin ad = 16'hC000 + 16'($urandom_range(0, 15)); c_i = ($urandom_range(0, 4) == 0); end
        2: begin ad = 16'hA000 + 16'($urandom_range(0, 15)); c_i = ($urandom_range(0, 4) != 0); end
        3: begin ad = 16'($urandom_range(0, 32767)); c_i = ($urandom_range(0, 4) != 0); end
        4: begin ad = 16'($urandom_range(0, 3) * 8192 + $urandom_range(0, 255)); c_i = 1; w_i = 1; end
        default: ad = 16'hE000 + 16'($urandom_range(0, 8191));
      endcase
      pp = ($urandom_range(0, 1) == 1) ? 16'h8000 + 16'($urandom_range(0, 15)) : 16'($urandom);
      bus_cycle("rand", ad, c_i, w_i, d, pp);
    end

    // reset in the middle of a write cycle
    step(1, 16'hC300, 0, 0, 0, blank("rst_p0", m_locked));
    m_locked = 1;
    step(0, 16'hFF40, 0, 0, 0, ppu_exp("rst_p1", 16'hFF40));
    step(0, 16'hC300, 0, 1, 8'h99, blank("rst_mid", 0));
    rst = 1;
    model_reset();
    step(0, 16'hC300, 0, 0, 0, blank("rst_hold", 0));
    rst = 0;
    bus_cycle("post_rst_wram", 16'hC300, 0, 0, 0, 16'hFF40);
    bus_cycle("post_rst_cram", 16'hA000, 1, 0, 0, 16'hFF40);
    bus_cycle("post_rst_rom",  16'h4000, 1, 0, 0, 16'hFF40);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
